mips_main_control: RTL and testbench

Multi-cycle main control FSM for the MIPS core. It decodes the 6-bit opcode of the instruction held in the instruction register, sequences fetch/decode/execute/memory/writeback, and drives datapath enables. It sits directly upstream of the ALU control decoder and supplies its 2-bit ALU_OP using the core's fixed encoding: 00 = R-type (funct decode), 01 = sw, 10 = lw/add, 11 = beq/sub. Memory accesses use a ready handshake with a timeout.

---
 rtl/mips_main_control_if.sv | 38 +++
 rtl/mips_main_control.sv | 163 ++++++++++++++++
 tb/tb_mips_main_control.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mips_main_control_if.sv
// Control bundle between the MIPS main-control FSM and the multi-cycle datapath.
// master = controller side, slave = datapath/memory side.
interface mips_main_control_if #(
    parameter int RET_W = 16
);
    logic [5:0]       Op;
    logic             Mem_Ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALU_OP;
    logic [1:0]       PCSource;
    logic [3:0]       State;
    logic             Illegal_Op;
    logic [RET_W-1:0] Retired;

    modport master (
        input  Op, Mem_Ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_OP, PCSource, State,
               Illegal_Op, Retired
    );

    modport slave (
        output Op, Mem_Ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALU_OP, PCSource, State,
               Illegal_Op, Retired
    );
endinterface

// File: rtl/mips_main_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// with a memory-ready timeout that traps into a sticky ERROR state.
module mips_main_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4,
    parameter int RET_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_main_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_LW    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BEQ      = 4'd8,
        S_JUMP     = 4'd9,
        S_ERROR    = 4'd10
    } state_t;

    localparam logic [5:0]       OP_R    = 6'b000000;
    localparam logic [5:0]       OP_LW   = 6'b100011;
    localparam logic [5:0]       OP_SW   = 6'b101011;
    localparam logic [5:0]       OP_BEQ  = 6'b000100;
    localparam logic [5:0]       OP_J    = 6'b000010;
    localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic [RET_W-1:0] retired_q;
    logic             is_sw_q, is_sw_d;
    logic             retire;
    logic             waiting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            is_sw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            is_sw_q <= is_sw_d;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    // Wait counter defaults to clear; it only counts while parked in a memory state.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        is_sw_d = is_sw_q;
        retire  = 1'b0;
        waiting = 1'b0;
        case (state_q)
            S_FETCH:    if (bus.Mem_Ready) state_d = S_DECODE; else waiting = 1'b1;
            S_DECODE: begin
                is_sw_d = (bus.Op == OP_SW);
                case (bus.Op)
                    OP_R:         state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEM_ADDR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.Mem_Ready) state_d = S_WB_LW; else waiting = 1'b1;
            S_MEM_WR: begin
                if (bus.Mem_Ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_WB_LW, S_R_WB, S_BEQ, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_FETCH;
        endcase
        if (waiting) begin
            if (wait_q == WAIT_LAST) state_d = S_ERROR;
            else                     wait_d  = wait_q + 1'b1;
        end
    end

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALU_OP      = 2'b00;
        bus.PCSource    = 2'b00;
        bus.Illegal_Op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.ALU_OP  = 2'b10;
                bus.IRWrite = bus.Mem_Ready;
                bus.PCWrite = bus.Mem_Ready;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ALU_OP  = 2'b10;
            end
            S_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALU_OP  = is_sw_q ? 2'b01 : 2'b10;
            end
            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_WB_LW: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_R_EXEC:   bus.ALUSrcA = 1'b1;
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_BEQ: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALU_OP      = 2'b11;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            S_ERROR:    bus.Illegal_Op = 1'b1;
            default: ;
        endcase
    end

    assign bus.State   = state_q;
    assign bus.Retired = retired_q;
endmodule

// File: tb/tb_mips_main_control.sv
// Randomized and directed bench for mips_main_control against an instruction-level model.
module tb_mips_main_control;
    localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, WB_LW = 4, MEM_WR = 5;
    localparam int R_EXEC = 6, R_WB = 7, BEQ = 8, JUMP = 9, ERROR = 10;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_ret = '0;
    logic [16:0] obs_outs;

    mips_main_control_if #(.RET_W(16)) bus ();

    mips_main_control #(.MEM_TIMEOUT(15), .TMO_W(4), .RET_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign obs_outs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                       bus.MemtoReg, bus.IRWrite, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                       bus.ALUSrcB, bus.ALU_OP, bus.PCSource, bus.Illegal_Op};

    // Control word each state must show, straight from the state descriptions.
    function automatic logic [16:0] exp_outs(int st, logic rdy, logic sw);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
        logic rdst = 0, rwr = 0, srca = 0, ill = 0;
        logic [1:0] srcb = 0, aop = 0, pcs = 0;
        case (st)
            FETCH:    begin mrd = 1; srcb = 2'b01; aop = 2'b10; irw = rdy; pcw = rdy; end
            DECODE:   begin srcb = 2'b11; aop = 2'b10; end
            MEM_ADDR: begin srca = 1; srcb = 2'b10; aop = sw ? 2'b01 : 2'b10; end
            MEM_RD:   begin mrd = 1; iord = 1; end
            WB_LW:    begin rwr = 1; m2r = 1; end
            MEM_WR:   begin mwr = 1; iord = 1; end
            R_EXEC:   begin srca = 1; end
            R_WB:     begin rwr = 1; rdst = 1; end
            BEQ:      begin srca = 1; aop = 2'b11; pcwc = 1; pcs = 2'b01; end
            JUMP:     begin pcw = 1; pcs = 2'b10; end
            ERROR:    ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rwr, srca, srcb, aop, pcs, ill};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts just after a falling edge; drives inputs, checks, then advances to the next falling edge.
    task automatic run_cycle(int st, logic rdy, logic [5:0] op, logic sw);
        bus.Mem_Ready = rdy;
        bus.Op        = op;
        #1;
        check("state", 32'(bus.State), 32'(st));
        check("outs", 32'(obs_outs), 32'(exp_outs(st, rdy, sw)));
        check("retired", 32'(bus.Retired), 32'(exp_ret));
        $display("cycle t=%0t state=%0d rdy=%0b op=%b retired=%0d", $time, st, rdy, op, exp_ret);
        @(negedge clk);
    endtask

    task automatic wait_then_ready(int st, int waits);
        for (int i = 0; i < waits; i++) run_cycle(st, 1'b0, 6'($urandom), 1'b0);
        run_cycle(st, 1'b1, 6'($urandom), 1'b0);
    endtask

    // One whole instruction as the spec sequences it; Op is garbage outside DECODE.
    task automatic run_instr(logic [5:0] op, int wf, int wm);
        wait_then_ready(FETCH, wf);
        run_cycle(DECODE, 1'($urandom), op, 1'b0);
        case (op)
            OP_R: begin
                run_cycle(R_EXEC, 1'($urandom), 6'($urandom), 1'b0);
                run_cycle(R_WB, 1'($urandom), 6'($urandom), 1'b0);
            end
            OP_LW: begin
                run_cycle(MEM_ADDR, 1'($urandom), 6'($urandom), 1'b0);
                wait_then_ready(MEM_RD, wm);
                run_cycle(WB_LW, 1'($urandom), 6'($urandom), 1'b0);
            end
            OP_SW: begin
                run_cycle(MEM_ADDR, 1'($urandom), 6'($urandom), 1'b1);
                wait_then_ready(MEM_WR, wm);
            end
            OP_BEQ: run_cycle(BEQ, 1'($urandom), 6'($urandom), 1'b0);
            default: run_cycle(JUMP, 1'($urandom), 6'($urandom), 1'b0);
        endcase
        exp_ret++;
        $display("instr op=%b fetch_waits=%0d mem_waits=%0d retired=%0d", op, wf, wm, exp_ret);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Mem_Ready = 1'b1;
        #1;
        exp_ret = '0;
        check("rst_state", 32'(bus.State), 32'(FETCH));
        check("rst_retired", 32'(bus.Retired), 32'd0);
        check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic error_hold(int n);
        for (int i = 0; i < n; i++) run_cycle(ERROR, 1'($urandom), 6'($urandom), 1'b0);
    endtask

    initial begin
        logic [5:0] ops [5];
        logic [5:0] bad;
        ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ; ops[4] = OP_J;
        bus.Op = '0;
        bus.Mem_Ready = 1'b0;
        do_reset();

        // Reset in the middle of MEM_ADDR aborts the load/store.
        run_cycle(FETCH, 1'b1, 6'($urandom), 1'b0);
        run_cycle(DECODE, 1'b1, OP_SW, 1'b0);
        #1;
        check("mid_state", 32'(bus.State), 32'(MEM_ADDR));
        #2;
        do_reset();

        run_instr(OP_R, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_LW, 10, 10);

        // Illegal opcode: ERROR is sticky until reset.
        run_cycle(FETCH, 1'b1, 6'($urandom), 1'b0);
        run_cycle(DECODE, 1'b1, 6'b111111, 1'b0);
        error_hold(20);
        do_reset();

        // Fetch timeout: the 15th consecutive not-ready cycle traps.
        for (int i = 0; i < 15; i++) run_cycle(FETCH, 1'b0, 6'($urandom), 1'b0);
        error_hold(3);
        do_reset();
        run_instr(OP_R, 14, 0);

        // Store timeout inside MEM_WR.
        run_cycle(FETCH, 1'b1, 6'($urandom), 1'b0);
        run_cycle(DECODE, 1'b0, OP_SW, 1'b0);
        run_cycle(MEM_ADDR, 1'b1, 6'($urandom), 1'b1);
        for (int i = 0; i < 15; i++) run_cycle(MEM_WR, 1'b0, 6'($urandom), 1'b0);
        error_hold(2);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            int wf = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            int wm = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            run_instr(ops[$urandom_range(0, 4)], wf, wm);
        end

        for (int n = 0; n < 3; n++) begin
            bad = 6'($urandom);
            while (bad == OP_R || bad == OP_LW || bad == OP_SW || bad == OP_BEQ || bad == OP_J)
                bad = 6'($urandom);
            run_cycle(FETCH, 1'b1, 6'($urandom), 1'b0);
            run_cycle(DECODE, 1'($urandom), bad, 1'b0);
            error_hold(4);
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
